// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS subset control path: state codes,
// instruction fields, ALU operations, datapath mux selects and the control word.
package ctrl_pkg;

  // Explicit encodings so the debug state output matches the documented numbering.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  // Opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // R-type function codes, instr[5:0].
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU32Bit operation codes.
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // ALU B operand select.
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SHL = 2'd3;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // One state's worth of datapath control. All-zero is the idle/reset word.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an R-type funct field to the ALU32Bit operation and flags unsupported codes.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluOp,
  output logic       valid
);

  // Pure lookup; unsupported funct returns AND with valid low.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    aluOp = ALU_AND;
    valid = 1'b1;
    case (funct)
      FN_ADD:  aluOp = ALU_ADD;
      FN_SUB:  aluOp = ALU_SUB;
      FN_AND:  aluOp = ALU_AND;
      FN_OR:   aluOp = ALU_OR;
      FN_SLT:  aluOp = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle MIPS subset datapath. Sequences each
// instruction through its states, emits all selects/enables and counts
// retired instructions.
module multi_cycle_control
  import ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcEn,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        regWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  pcSource,
  output logic [2:0]  aluOp,
  output logic [3:0]  state,
  output logic        instrDone,
  output logic        illegal,
  output logic [31:0] instrCount
);

  state_t      state_q;
  state_t      next_state;
  ctrl_t       ctrl;
  ctrl_t       ctrl_g;
  logic [2:0]  funct_alu_op;
  logic        funct_valid;
  logic [31:0] instr_count_q;

  alu_op_decoder u_alu_op_decoder (
    .funct (funct),
    .aluOp (funct_alu_op),
    .valid (funct_valid)
  );

  // State register and retired-instruction counter; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q <= next_state;
      if (ctrl_g.instr_done) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
    end
  end

  // Next-state and control word decode from the current state.
  always_comb begin
    ctrl       = '0;
    next_state = S_FETCH;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
        next_state     = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target in ALUOut while decoding.
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SHL;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct_valid) begin
              next_state = S_R_EXEC;
            end else begin
              ctrl.illegal = 1'b1;
            end
          end
          OP_BEQ:  next_state = S_BRANCH;
          OP_J:    next_state = S_JUMP;
          OP_ADDI: next_state = S_I_EXEC;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        next_state    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = funct_alu_op;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      default: begin
        // Unused encodings emit nothing and recover to FETCH.
        next_state = S_FETCH;
      end
    endcase
  end

  // While reset is low every output is driven idle, independent of the state register.
  always_comb begin
    ctrl_g = reset ? ctrl : '0;
  end

  assign pcEn       = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero);
  assign iorD       = ctrl_g.iord;
  assign memRead    = ctrl_g.mem_read;
  assign memWrite   = ctrl_g.mem_write;
  assign irWrite    = ctrl_g.ir_write;
  assign regDst     = ctrl_g.reg_dst;
  assign memToReg   = ctrl_g.mem_to_reg;
  assign regWrite   = ctrl_g.reg_write;
  assign aluSrcA    = ctrl_g.alu_src_a;
  assign aluSrcB    = ctrl_g.alu_src_b;
  assign pcSource   = ctrl_g.pc_source;
  assign aluOp      = ctrl_g.alu_op;
  assign instrDone  = ctrl_g.instr_done;
  assign illegal    = ctrl_g.illegal;
  assign state      = state_q;
  assign instrCount = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control. Inputs change just
// after the falling edge; outputs are sampled 1 ns later.
module tb_multi_cycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, pcSource;
  logic [2:0]  aluOp;
  logic [3:0]  state;
  logic        instrDone, illegal;
  logic [31:0] instrCount;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_count;

  multi_cycle_control dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pcEn       (pcEn),
    .iorD       (iorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .pcSource   (pcSource),
    .aluOp      (aluOp),
    .state      (state),
    .instrDone  (instrDone),
    .illegal    (illegal),
    .instrCount (instrCount)
  );

  always #5 clock = ~clock;

  // Advance to just after the next falling edge.
  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
    #1;
    n_checks++;
    if ({pcEn, memRead, memWrite, irWrite, regWrite, instrDone, illegal} !== 7'b0) begin
      n_fail++; $display("FAIL reset_enables_pre_edge: got %b want 0000000",
                         {pcEn, memRead, memWrite, irWrite, regWrite, instrDone, illegal});
    end
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      next_cycle();
      n_checks++;
      if ({pcEn, memRead, memWrite, irWrite, regWrite, instrDone, illegal, iorD, regDst,
           memToReg, aluSrcA} !== 11'b0) begin
        n_fail++; $display("FAIL reset_bits_cycle%0d: got %b want all zero", i,
                           {pcEn, memRead, memWrite, irWrite, regWrite, instrDone, illegal,
                            iorD, regDst, memToReg, aluSrcA});
      end
      n_checks++;
      if ({aluSrcB, pcSource, aluOp} !== 7'b0) begin
        n_fail++; $display("FAIL reset_selects_cycle%0d: got %b want 0000000", i,
                           {aluSrcB, pcSource, aluOp});
      end
      n_checks++;
      if (state !== 4'd0 || instrCount !== 32'd0) begin
        n_fail++; $display("FAIL reset_state_count_cycle%0d: got state=%0d count=%0d want 0/0",
                           i, state, instrCount);
      end
    end
    reset = 1'b1;
    opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || pcEn !== 1'b1 || memRead !== 1'b1 || aluSrcB !== 2'd1 ||
        iorD !== 1'b0 || aluOp !== 3'd2) begin
      n_fail++; $display("FAIL release_fetch: got state=%0d pcEn=%b memRead=%b aluSrcB=%0d iorD=%b aluOp=%0d want 0/1/1/1/0/2",
                         state, pcEn, memRead, aluSrcB, iorD, aluOp);
    end
    exp_count = 32'd0;
  endtask

  task automatic test_rtype_sub();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = 6'h00; funct = 6'h22; zero = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      n_checks++;
      if (state !== seq[i]) begin
        n_fail++; $display("FAIL sub_state_step%0d: got %0d want %0d", i, state, seq[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (irWrite !== 1'b1 || aluSrcB !== 2'd3 || illegal !== 1'b0 || pcEn !== 1'b0) begin
          n_fail++; $display("FAIL sub_decode: got irWrite=%b aluSrcB=%0d illegal=%b pcEn=%b want 1/3/0/0",
                             irWrite, aluSrcB, illegal, pcEn);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (aluOp !== 3'd6 || aluSrcA !== 1'b1 || aluSrcB !== 2'd0 || regWrite !== 1'b0) begin
          n_fail++; $display("FAIL sub_exec: got aluOp=%0d aluSrcA=%b aluSrcB=%0d regWrite=%b want 6/1/0/0",
                             aluOp, aluSrcA, aluSrcB, regWrite);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (regWrite !== 1'b1 || regDst !== 1'b1 || memToReg !== 1'b0 || instrDone !== 1'b1) begin
          n_fail++; $display("FAIL sub_wb: got regWrite=%b regDst=%b memToReg=%b instrDone=%b want 1/1/0/1",
                             regWrite, regDst, memToReg, instrDone);
        end
      end
    end
    exp_count = exp_count + 32'd1;
    next_cycle();
    n_checks++;
    if (state !== 4'd0 || instrCount !== exp_count) begin
      n_fail++; $display("FAIL sub_retire: got state=%0d count=%0d want 0/%0d", state, instrCount, exp_count);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0] fn_tab [4] = '{6'h20, 6'h24, 6'h25, 6'h2A};
    logic [2:0] op_tab [4] = '{3'd2, 3'd0, 3'd1, 3'd7};
    for (int k = 0; k < 4; k++) begin
      opcode = 6'h00; funct = fn_tab[k];
      #1;
      next_cycle();
      next_cycle();
      n_checks++;
      if (state !== 4'd6 || aluOp !== op_tab[k]) begin
        n_fail++; $display("FAIL aluop_funct_%h: got state=%0d aluOp=%0d want 6/%0d",
                           fn_tab[k], state, aluOp, op_tab[k]);
      end
      next_cycle();
      next_cycle();
      exp_count = exp_count + 32'd1;
    end
    n_checks++;
    if (state !== 4'd0 || instrCount !== exp_count) begin
      n_fail++; $display("FAIL aluop_retire: got state=%0d count=%0d want 0/%0d", state, instrCount, exp_count);
    end
  endtask

  task automatic test_memory();
    logic [3:0] lw_seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] sw_seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    opcode = 6'h23; funct = 6'h00;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      n_checks++;
      if (state !== lw_seq[i]) begin
        n_fail++; $display("FAIL lw_state_step%0d: got %0d want %0d", i, state, lw_seq[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (aluSrcA !== 1'b1 || aluSrcB !== 2'd2 || aluOp !== 3'd2) begin
          n_fail++; $display("FAIL lw_addr: got aluSrcA=%b aluSrcB=%0d aluOp=%0d want 1/2/2",
                             aluSrcA, aluSrcB, aluOp);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (memRead !== 1'b1 || iorD !== 1'b1 || regWrite !== 1'b0) begin
          n_fail++; $display("FAIL lw_read: got memRead=%b iorD=%b regWrite=%b want 1/1/0",
                             memRead, iorD, regWrite);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (memToReg !== 1'b1 || regWrite !== 1'b1 || regDst !== 1'b0 || instrDone !== 1'b1) begin
          n_fail++; $display("FAIL lw_wb: got memToReg=%b regWrite=%b regDst=%b instrDone=%b want 1/1/0/1",
                             memToReg, regWrite, regDst, instrDone);
        end
      end
    end
    exp_count = exp_count + 32'd1;
    next_cycle();
    opcode = 6'h2B;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      n_checks++;
      if (state !== sw_seq[i]) begin
        n_fail++; $display("FAIL sw_state_step%0d: got %0d want %0d", i, state, sw_seq[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (memWrite !== 1'b1 || iorD !== 1'b1 || memRead !== 1'b0 || regWrite !== 1'b0 ||
            instrDone !== 1'b1) begin
          n_fail++; $display("FAIL sw_write: got memWrite=%b iorD=%b memRead=%b regWrite=%b instrDone=%b want 1/1/0/0/1",
                             memWrite, iorD, memRead, regWrite, instrDone);
        end
      end
    end
    exp_count = exp_count + 32'd1;
    next_cycle();
    n_checks++;
    if (state !== 4'd0 || instrCount !== exp_count) begin
      n_fail++; $display("FAIL mem_retire: got state=%0d count=%0d want 0/%0d", state, instrCount, exp_count);
    end
  endtask

  task automatic test_beq();
    logic       z_tab [2]  = '{1'b1, 1'b0};
    logic       en_tab [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      opcode = 6'h04; zero = z_tab[k];
      #1;
      n_checks++;
      if (state !== 4'd0 || pcEn !== 1'b1) begin
        n_fail++; $display("FAIL beq%0d_fetch: got state=%0d pcEn=%b want 0/1", k, state, pcEn);
      end
      next_cycle();
      next_cycle();
      n_checks++;
      if (state !== 4'd8 || pcEn !== en_tab[k] || pcSource !== 2'd1 || aluOp !== 3'd6 ||
          instrDone !== 1'b1) begin
        n_fail++; $display("FAIL beq_zero%0d_branch: got state=%0d pcEn=%b pcSource=%0d aluOp=%0d instrDone=%b want 8/%b/1/6/1",
                           z_tab[k], state, pcEn, pcSource, aluOp, instrDone, en_tab[k]);
      end
      exp_count = exp_count + 32'd1;
      next_cycle();
      n_checks++;
      if (state !== 4'd0 || instrCount !== exp_count) begin
        n_fail++; $display("FAIL beq_zero%0d_retire: got state=%0d count=%0d want 0/%0d",
                           z_tab[k], state, instrCount, exp_count);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] addi_seq [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    opcode = 6'h08;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      n_checks++;
      if (state !== addi_seq[i]) begin
        n_fail++; $display("FAIL addi_state_step%0d: got %0d want %0d", i, state, addi_seq[i]);
      end
    end
    n_checks++;
    if (regWrite !== 1'b1 || regDst !== 1'b0 || memToReg !== 1'b0 || instrDone !== 1'b1) begin
      n_fail++; $display("FAIL addi_wb: got regWrite=%b regDst=%b memToReg=%b instrDone=%b want 1/0/0/1",
                         regWrite, regDst, memToReg, instrDone);
    end
    exp_count = exp_count + 32'd1;
    next_cycle();
    opcode = 6'h02;
    #1;
    next_cycle();
    next_cycle();
    n_checks++;
    if (state !== 4'd9 || pcEn !== 1'b1 || pcSource !== 2'd2 || instrDone !== 1'b1) begin
      n_fail++; $display("FAIL jump: got state=%0d pcEn=%b pcSource=%0d instrDone=%b want 9/1/2/1",
                         state, pcEn, pcSource, instrDone);
    end
    exp_count = exp_count + 32'd1;
    next_cycle();
    n_checks++;
    if (state !== 4'd0 || instrCount !== exp_count) begin
      n_fail++; $display("FAIL b2b_retire: got state=%0d count=%0d want 0/%0d", state, instrCount, exp_count);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op_tab [2] = '{6'h3F, 6'h00};
    logic [5:0] fn_tab [2] = '{6'h20, 6'h27};
    for (int k = 0; k < 2; k++) begin
      opcode = op_tab[k]; funct = fn_tab[k];
      #1;
      next_cycle();
      n_checks++;
      if (state !== 4'd1 || illegal !== 1'b1 || instrDone !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_decode: got state=%0d illegal=%b instrDone=%b want 1/1/0",
                           k, state, illegal, instrDone);
      end
      next_cycle();
      n_checks++;
      if (state !== 4'd0 || illegal !== 1'b0 || instrCount !== exp_count) begin
        n_fail++; $display("FAIL illegal%0d_return: got state=%0d illegal=%b count=%0d want 0/0/%0d",
                           k, state, illegal, instrCount, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    opcode = 6'h23; funct = 6'h00;
    #1;
    next_cycle();
    next_cycle();
    next_cycle();
    n_checks++;
    if (state !== 4'd3 || memRead !== 1'b1) begin
      n_fail++; $display("FAIL midlw_reach_read: got state=%0d memRead=%b want 3/1", state, memRead);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (memRead !== 1'b0 || iorD !== 1'b0 || regWrite !== 1'b0 || pcEn !== 1'b0) begin
      n_fail++; $display("FAIL midlw_forced_idle: got memRead=%b iorD=%b regWrite=%b pcEn=%b want 0/0/0/0",
                         memRead, iorD, regWrite, pcEn);
    end
    next_cycle();
    n_checks++;
    if (state !== 4'd0 || instrCount !== 32'd0 || regWrite !== 1'b0) begin
      n_fail++; $display("FAIL midlw_after_edge: got state=%0d count=%0d regWrite=%b want 0/0/0",
                         state, instrCount, regWrite);
    end
    exp_count = 32'd0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || pcEn !== 1'b1 || memRead !== 1'b1) begin
      n_fail++; $display("FAIL midlw_release: got state=%0d pcEn=%b memRead=%b want 0/1/1",
                         state, pcEn, memRead);
    end
  endtask

  task automatic test_count_wrap();
    opcode = 6'h02;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    next_cycle();
    next_cycle();
    release dut.instr_count_q;
    #1;
    n_checks++;
    if (state !== 4'd9 || instrCount !== 32'hFFFF_FFFF || instrDone !== 1'b1) begin
      n_fail++; $display("FAIL wrap_preload: got state=%0d count=%h instrDone=%b want 9/ffffffff/1",
                         state, instrCount, instrDone);
    end
    next_cycle();
    n_checks++;
    if (state !== 4'd0 || instrCount !== 32'd0) begin
      n_fail++; $display("FAIL wrap_count: got state=%0d count=%h want 0/00000000", state, instrCount);
    end
  endtask

  // Watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype_sub();
    test_alu_ops();
    test_memory();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_lw();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
